// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency fetch pipeline with flush and side-band load port.
// Optional misaligned/out-of-range fault checking is enabled by defining IMEM_FAULT_CHECK_EN.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [63:0]                      i_inst_addr,
    input  logic                             i_inst_ena,
    input  logic                             i_flush,
    input  logic                             i_load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0]   i_load_addr,
    input  logic [31:0]                      i_load_data,
    output logic [31:0]                      o_inst,
    output logic                             o_inst_valid,
    output logic                             o_inst_fault,
    output logic [$clog2(LATENCY+1)-1:0]     o_inflight
);

    localparam int unsigned AW  = $clog2(DEPTH_WORDS);
    localparam int unsigned CW  = $clog2(LATENCY + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]        r_mem [DEPTH_WORDS];
    logic [31:0]        r_data [LATENCY];
    logic [LATENCY-1:0] r_valid;
    logic [LATENCY-1:0] r_fault;
    logic [CW-1:0]      r_inflight;
    logic [CW-1:0]      w_inflight_next;
    logic [AW-1:0]      w_rd_idx;
    logic               w_fault;
    logic               w_emit;

    assign w_rd_idx = i_inst_addr[AW+1:2];

`ifdef IMEM_FAULT_CHECK_EN
    assign w_fault = (i_inst_addr[1:0] != 2'b00) || (i_inst_addr[63:AW+2] != '0);
`else
    // Without checking, low bits are ignored and upper bits alias.
    logic w_unused_addr;
    assign w_unused_addr = ^{i_inst_addr[63:AW+2], i_inst_addr[1:0]};
    assign w_fault       = 1'b0;
`endif

    // Memory is deliberately left out of the reset branch so contents survive reset,
    // while writes are still blocked whenever reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (i_load_en) begin
                r_mem[i_load_addr] <= i_load_data;
            end
            r_data[0] <= r_mem[w_rd_idx];
            for (int i = 1; i < LATENCY; i++) begin
                r_data[i] <= r_data[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_fault    <= '0;
            r_inflight <= '0;
        end else begin
            // Stage 0 ignores flush: a request alongside flush is the redirect target.
            r_valid[0] <= i_inst_ena;
            r_fault[0] <= w_fault;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1] & ~i_flush;
                r_fault[i] <= r_fault[i-1];
            end
            r_inflight <= w_inflight_next;
        end
    end

    always_comb begin
        w_emit          = r_valid[LATENCY-1] & ~i_flush;
        w_inflight_next = r_inflight;
        if (i_flush) begin
            w_inflight_next = CW'(i_inst_ena);
        end else begin
            w_inflight_next = r_inflight + CW'(i_inst_ena) - CW'(w_emit);
        end
    end

    always_comb begin
        o_inst_valid = w_emit;
        o_inst_fault = w_emit & r_fault[LATENCY-1];
        o_inst       = '0;
        if (w_emit) begin
            o_inst = r_fault[LATENCY-1] ? NOP : r_data[LATENCY-1];
        end
    end

    assign o_inflight = r_inflight;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: queue-based response model plus pinned literal expectations.
module tb_imem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(LAT + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [63:0]   inst_addr = '0;
    logic          inst_ena = 1'b0;
    logic          flush = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;
    logic [31:0]   inst;
    logic          inst_valid;
    logic          inst_fault;
    logic [CW-1:0] inflight;

    imem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_inst_addr  (inst_addr),
        .i_inst_ena   (inst_ena),
        .i_flush      (flush),
        .i_load_en    (load_en),
        .i_load_addr  (load_addr),
        .i_load_data  (load_data),
        .o_inst       (inst),
        .o_inst_valid (inst_valid),
        .o_inst_fault (inst_fault),
        .o_inflight   (inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        fault;
    } resp_t;

    typedef struct packed {
        logic        v;
        logic        f;
        logic [31:0] d;
    } lit_t;

    resp_t       q[$];
    logic [31:0] shadow [DEPTH];
    int          cyc = 0;
    lit_t        lit_tab [int];
    int          lit_infl [int];
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic void model_read(input logic [63:0] a, output logic [31:0] d,
                                       output logic f);
        logic [63:0] word;
        f = 1'b0;
`ifdef IMEM_FAULT_CHECK_EN
        f = (a % 64'd4 != 64'd0) || (a >= 64'(DEPTH) * 64'd4);
`endif
        word = (a / 64'd4) % 64'(DEPTH);
        d    = f ? 32'h0000_0013 : shadow[int'(word)];
    endfunction

    // Model: every accepted request becomes a response due LAT-1 cycles after its edge.
    initial begin
        logic [31:0] d;
        logic        f;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
            end else begin
                cyc = cyc + 1;
                while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
                if (flush) q.delete();
                if (inst_ena) begin
                    model_read(inst_addr, d, f);
                    q.push_back('{due: cyc + int'(LAT) - 1, data: d, fault: f});
                end
                if (load_en) shadow[load_addr] = load_data;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc,
                     $time);
        end
    endtask

    initial begin
        logic        exp_v;
        logic        exp_f;
        logic [31:0] exp_d;
        int          exp_n;
        lit_t        l;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            exp_v = 1'b0;
            exp_f = 1'b0;
            exp_d = '0;
            exp_n = 0;
            if (rst_n) begin
                exp_n = q.size();
                if (!flush && q.size() > 0 && q[0].due == cyc) begin
                    exp_v = 1'b1;
                    exp_d = q[0].data;
                    exp_f = q[0].fault;
                end
            end
            check("inst_valid", 64'(inst_valid), 64'(exp_v));
            check("inst", 64'(inst), 64'(exp_d));
            check("inst_fault", 64'(inst_fault), 64'(exp_f));
            check("inflight", 64'(inflight), 64'(exp_n));
            if (rst_n && lit_tab.exists(cyc)) begin
                l = lit_tab[cyc];
                check("pin_valid", 64'(inst_valid), 64'(l.v));
                check("pin_inst", 64'(inst), 64'(l.d));
                check("pin_fault", 64'(inst_fault), 64'(l.f));
            end
            if (rst_n && lit_infl.exists(cyc)) begin
                check("pin_inflight", 64'(inflight), 64'(lit_infl[cyc]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [63:0] a);
        inst_ena  = 1'b1;
        inst_addr = a;
        tick();
    endtask

    task automatic pin(input int c, input logic v, input logic f, input logic [31:0] d);
        lit_tab[c] = '{v: v, f: f, d: d};
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_data = 32'h11 * (i + 1);
            tick();
        end
        load_addr = AW'(5);
        load_data = 32'h55;
        tick();
        load_en = 1'b0;
        tick();

        // Back-to-back stream
        for (int i = 0; i < 4; i++) begin
            req(64'(4 * i));
            pin(cyc + int'(LAT) - 1, 1'b1, 1'b0, 32'h11 * (i + 1));
            if (i == 1) lit_infl[cyc] = 2;
        end
        inst_ena = 1'b0;
        repeat (3) tick();

        // Flush with a redirect request in the flush cycle
        req(64'd0);
        req(64'd4);
        pin(cyc, 1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        req(64'd8);
        pin(cyc, 1'b0, 1'b0, 32'h0);
        pin(cyc + 1, 1'b1, 1'b0, 32'h33);
        lit_infl[cyc]     = 1;
        lit_infl[cyc + 2] = 0;
        flush    = 1'b0;
        inst_ena = 1'b0;
        repeat (3) tick();

        // Misaligned / out-of-range / aliasing
        req(64'h2);
`ifdef IMEM_FAULT_CHECK_EN
        pin(cyc + 1, 1'b1, 1'b1, 32'h13);
`else
        pin(cyc + 1, 1'b1, 1'b0, 32'h11);
`endif
        req(64'h1000);
`ifdef IMEM_FAULT_CHECK_EN
        pin(cyc + 1, 1'b1, 1'b1, 32'h13);
`else
        pin(cyc + 1, 1'b1, 1'b0, 32'h11);
`endif
        req(64'h1004);
`ifdef IMEM_FAULT_CHECK_EN
        pin(cyc + 1, 1'b1, 1'b1, 32'h13);
`else
        pin(cyc + 1, 1'b1, 1'b0, 32'h22);
`endif
        req(64'h0);
        pin(cyc + 1, 1'b1, 1'b0, 32'h11);
        inst_ena = 1'b0;
        repeat (3) tick();

        // Read/write collision returns old data
        load_en   = 1'b1;
        load_addr = AW'(1);
        load_data = 32'hAA;
        req(64'd4);
        pin(cyc + 1, 1'b1, 1'b0, 32'h22);
        load_en = 1'b0;
        req(64'd4);
        pin(cyc + 1, 1'b1, 1'b0, 32'hAA);
        inst_ena = 1'b0;
        repeat (3) tick();

        // Asynchronous reset mid-stream; load during reset must be dropped
        req(64'd0);
        req(64'd4);
        #2;
        rst_n     = 1'b0;
        inst_ena  = 1'b0;
        load_en   = 1'b1;
        load_addr = AW'(5);
        load_data = 32'hBAD;
        repeat (2) tick();
        load_en = 1'b0;
        rst_n   = 1'b1;
        tick();
        req(64'd0);
        pin(cyc + 1, 1'b1, 1'b0, 32'h11);
        req(64'd20);
        pin(cyc + 1, 1'b1, 1'b0, 32'h55);
        inst_ena = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
